// File: rtl/step_metrics_if.sv
// Step-metrics bus: step pulse and clear in, registered activity metrics out.
interface step_metrics_if;
    logic        pulse_in;
    logic        clear;
    logic [13:0] total_steps;
    logic [12:0] distance_m;
    logic [7:0]  steps_per_sec;
    logic [3:0]  early_score;
    logic [15:0] hi_secs;
    logic        sec_tick;

    modport master (
        output pulse_in, clear,
        input  total_steps, distance_m, steps_per_sec, early_score, hi_secs, sec_tick
    );

    modport slave (
        input  pulse_in, clear,
        output total_steps, distance_m, steps_per_sec, early_score, hi_secs, sec_tick
    );
endinterface

// File: rtl/step_metrics.sv
// Step-pulse activity metrics: total steps, distance, per-second rate,
// early-window score and accumulated high-activity seconds, on a 1 s timebase.
module step_metrics #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned STEP_MAX     = 9999,
    parameter int unsigned EARLY_SECS   = 9,
    parameter int unsigned EARLY_THRESH = 32,
    parameter int unsigned HI_RATE      = 64,
    parameter int unsigned HI_RUN       = 60
) (
    input logic          clk,
    input logic          reset,
    step_metrics_if.slave bus
);
    localparam int unsigned TBW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned RLW = $clog2(HI_RUN + 1);

    typedef enum logic [1:0] {IDLE, BUILD, ACTIVE} hi_state_e;

    logic           in_q, in_qq, step_q, step_d;
    logic [TBW-1:0] tb_cnt_q, tb_cnt_d;
    logic           sec_tick_q, sec_tick_d;
    logic [7:0]     sec_cnt_q, sec_cnt_d;
    logic [7:0]     sps_q, sps_d;
    logic [13:0]    total_q, total_d;
    logic [12:0]    dist_q, dist_d;
    logic [3:0]     secs_el_q, secs_el_d;
    logic [3:0]     early_q, early_d;
    logic [15:0]    hi_q, hi_d;
    logic [RLW-1:0] run_len_q, run_len_d, run_len_inc;
    hi_state_e      state_q, state_d;
    logic [7:0]     completed;
    logic           high_sec;
    logic [16:0]    credit, hi_sum;

    always_comb begin
        step_d      = in_q & ~in_qq;
        tb_cnt_d    = (tb_cnt_q == TBW'(CLK_HZ - 1)) ? '0 : tb_cnt_q + 1'b1;
        sec_tick_d  = (tb_cnt_d == TBW'(CLK_HZ - 1));
        sec_cnt_d   = sec_cnt_q;
        sps_d       = sps_q;
        total_d     = total_q;
        secs_el_d   = secs_el_q;
        early_d     = early_q;
        run_len_d   = run_len_q;
        run_len_inc = run_len_q + 1'b1;
        state_d     = state_q;
        credit      = '0;

        // A step landing in the tick cycle is folded into the second that ends.
        completed = (step_q && sec_cnt_q != 8'hFF) ? sec_cnt_q + 8'd1 : sec_cnt_q;
        high_sec  = (32'(completed) >= HI_RATE);

        if (step_q && total_q < 14'(STEP_MAX))
            total_d = total_q + 14'd1;

        if (sec_tick_q) begin
            sps_d     = completed;
            sec_cnt_d = '0;
            if (secs_el_q < 4'(EARLY_SECS)) begin
                secs_el_d = secs_el_q + 4'd1;
                if (32'(completed) > EARLY_THRESH)
                    early_d = early_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    if (high_sec) begin
                        run_len_d = RLW'(1);
                        state_d   = BUILD;
                    end
                end
                BUILD: begin
                    if (high_sec) begin
                        run_len_d = run_len_inc;
                        if (run_len_inc == RLW'(HI_RUN)) begin
                            credit  = 17'(HI_RUN);
                            state_d = ACTIVE;
                        end
                    end else begin
                        run_len_d = '0;
                        state_d   = IDLE;
                    end
                end
                ACTIVE: begin
                    if (high_sec) begin
                        credit = 17'd1;
                    end else begin
                        run_len_d = '0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (step_q && sec_cnt_q != 8'hFF) begin
            sec_cnt_d = sec_cnt_q + 8'd1;
        end

        hi_sum = {1'b0, hi_q} + credit;
        hi_d   = hi_sum[16] ? '1 : hi_sum[15:0];

        // Clear wipes the metrics but leaves the edge detector sampling.
        if (bus.clear) begin
            tb_cnt_d   = '0;
            sec_tick_d = 1'b0;
            sec_cnt_d  = '0;
            sps_d      = '0;
            total_d    = '0;
            secs_el_d  = '0;
            early_d    = '0;
            hi_d       = '0;
            run_len_d  = '0;
            state_d    = IDLE;
        end

        dist_d = total_d[13:1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q       <= 1'b0;
            in_qq      <= 1'b0;
            step_q     <= 1'b0;
            tb_cnt_q   <= '0;
            sec_tick_q <= 1'b0;
            sec_cnt_q  <= '0;
            sps_q      <= '0;
            total_q    <= '0;
            dist_q     <= '0;
            secs_el_q  <= '0;
            early_q    <= '0;
            hi_q       <= '0;
            run_len_q  <= '0;
            state_q    <= IDLE;
        end else begin
            in_q       <= bus.pulse_in;
            in_qq      <= in_q;
            step_q     <= step_d;
            tb_cnt_q   <= tb_cnt_d;
            sec_tick_q <= sec_tick_d;
            sec_cnt_q  <= sec_cnt_d;
            sps_q      <= sps_d;
            total_q    <= total_d;
            dist_q     <= dist_d;
            secs_el_q  <= secs_el_d;
            early_q    <= early_d;
            hi_q       <= hi_d;
            run_len_q  <= run_len_d;
            state_q    <= state_d;
        end
    end

    assign bus.total_steps   = total_q;
    assign bus.distance_m    = dist_q;
    assign bus.steps_per_sec = sps_q;
    assign bus.early_score   = early_q;
    assign bus.hi_secs       = hi_q;
    assign bus.sec_tick      = sec_tick_q;
endmodule
